// File: rtl/regfile_wb_arbiter.sv
// RF write-port arbiter: pipeline write-back over a queue of long-latency unit results.
// Optional WB_ARB_BYPASS_EN: unit result goes straight to the RF port when the queue is empty.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [AW-1:0]          pipe_waddr,
  input  logic [DW-1:0]          pipe_wdata,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [AW-1:0]          lu_waddr,
  input  logic [DW-1:0]          lu_wdata,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  output logic [31:0]            pend_mask,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_val;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_rf_we;
  logic [AW-1:0]    r_rf_waddr;
  logic [DW-1:0]    r_rf_wdata;

  logic             w_xfer;
  logic             w_lu_zero;
  logic             w_pipe_kill;
  logic             w_kill_new;
  logic             w_pop;
  logic             w_push;
  logic             w_byp;
  logic [31:0]      w_mask;

  assign lu_ready    = !rst && (r_count < CW'(DEPTH));
  assign w_xfer      = lu_valid && lu_ready;
  assign w_lu_zero   = (lu_waddr == '0);
  assign w_pipe_kill = pipe_we && (pipe_waddr != '0);
  assign w_kill_new  = w_pipe_kill && (lu_waddr == pipe_waddr);
  assign w_pop       = !pipe_we && (r_count != '0);

`ifdef WB_ARB_BYPASS_EN
  assign w_byp = w_xfer && !w_lu_zero && !pipe_we
               && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_xfer && !w_lu_zero && !w_byp;

  // Queue state: squash younger-overwritten entries, pop head, push tail
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pipe_kill && (r_addr[i] == pipe_waddr))
          r_val[i] <= 1'b0;
      end
      if (w_pop) begin
        r_val[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_val[r_tail]  <= !w_kill_new;
        r_addr[r_tail] <= lu_waddr;
        r_data[r_tail] <= lu_wdata;
        r_tail         <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // RF write port: pipeline, then queue head, then bypass, else idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      unique case (1'b1)
        pipe_we: begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= pipe_waddr;
          r_rf_wdata <= pipe_wdata;
        end
        w_pop: begin
          r_rf_we    <= r_val[r_head];
          r_rf_waddr <= r_addr[r_head];
          r_rf_wdata <= r_data[r_head];
        end
        w_byp: begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= lu_waddr;
          r_rf_wdata <= lu_wdata;
        end
        default: r_rf_we <= 1'b0;
      endcase
    end
  end

  // Pending-write mask over valid queued entries
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_val[i])
        w_mask[r_addr[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  assign pend_mask = w_mask;
  assign q_count   = r_count;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Expected RF writes are queued per test and matched on every rf_we.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [1:0]  q_count;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q [$];
  logic [31:0] rf_m [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_mask  (pend_mask),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [4:0] a,
                           input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    pipe_we    = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    lu_valid   = 1'b0;
    lu_waddr   = '0;
    lu_wdata   = '0;
  endtask

  // Scoreboard: every RF write must match the next expected write
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexp_wr", 32'(rf_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_waddr), 32'(e.a));
        chk("wr_data", rf_wdata, e.d);
      end
      rf_m[rf_waddr] = rf_wdata;
    end
  end

  initial begin
    int li;
    logic acc;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt", 32'(q_count), 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_rdy", 32'(lu_ready), 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(lu_ready), 1);

    // T1: plain pipeline write
    expect_wr(5'd3, 32'h11);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    tick();
    idle();
    chk("t1_we", 32'(rf_we), 1);
    chk("t1_cnt", 32'(q_count), 0);
    tick();
    chk("t1_idle_we", 32'(rf_we), 0);

    // T2: lone unit result
    expect_wr(5'd5, 32'hAB);
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hAB;
    tick();
    idle();
`ifdef WB_ARB_BYPASS_EN
    chk("t2_byp_we", 32'(rf_we), 1);
    chk("t2_byp_pend", pend_mask, 0);
    chk("t2_byp_cnt", 32'(q_count), 0);
`else
    chk("t2_pend", pend_mask, 32'h20);
    chk("t2_cnt", 32'(q_count), 1);
    chk("t2_we0", 32'(rf_we), 0);
    tick();
    chk("t2_we", 32'(rf_we), 1);
    chk("t2_pend_clr", pend_mask, 0);
    chk("t2_cnt0", 32'(q_count), 0);
`endif
    tick();
    chk("t2_idle_we", 32'(rf_we), 0);

    // T3: pipeline hogs the port while unit results back up
    for (int c = 0; c < 4; c++)
      expect_wr(5'(10 + c), 32'h100 + 32'(c));
    for (int k = 0; k < 3; k++)
      expect_wr(5'(6 + k), 32'h200 + 32'(k));
    li = 0;
    for (int c = 0; c < 12; c++) begin
      pipe_we    = (c < 4);
      pipe_waddr = 5'(10 + c);
      pipe_wdata = 32'h100 + 32'(c);
      lu_valid   = (li < 3);
      lu_waddr   = 5'(6 + li);
      lu_wdata   = 32'h200 + 32'(li);
      #1;
      if (c == 2) begin
        chk("t3_rdy_full", 32'(lu_ready), 0);
        chk("t3_cnt_full", 32'(q_count), 2);
        chk("t3_pend", pend_mask, 32'h0C0);
      end
      if (c == 4)
        chk("t3_rdy_pop", 32'(lu_ready), 0);
      acc = lu_valid && lu_ready;
      tick();
      if (acc) li++;
    end
    idle();
    chk("t3_all_acc", li, 3);
    chk("t3_cnt_end", 32'(q_count), 0);

    // T4: pipeline write squashes a queued entry and an incoming one
    expect_wr(5'd20, 32'h1);
    expect_wr(5'd9, 32'h55);
    pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'h1;
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    tick();
    lu_valid = 1'b0;
    chk("t4_pend9", pend_mask, 32'h200);
    pipe_waddr = 5'd9; pipe_wdata = 32'h55;
    tick();
    idle();
    chk("t4_pend_sq", pend_mask, 0);
    chk("t4_cnt_sq", 32'(q_count), 1);
    tick();
    chk("t4_drain_we", 32'(rf_we), 0);
    chk("t4_cnt0", 32'(q_count), 0);
    chk("t4_rf9", rf_m[9], 32'h55);
    expect_wr(5'd21, 32'h2);
    pipe_we = 1'b1; pipe_waddr = 5'd21; pipe_wdata = 32'h2;
    lu_valid = 1'b1; lu_waddr = 5'd21; lu_wdata = 32'h3;
    tick();
    idle();
    chk("t4_new_cnt", 32'(q_count), 1);
    chk("t4_new_pend", pend_mask, 0);
    tick();
    chk("t4_new_we", 32'(rf_we), 0);
    chk("t4_rf21", rf_m[21], 32'h2);

    // T5: unit write to x0 is dropped
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hFF;
    tick();
    idle();
    chk("t5_cnt", 32'(q_count), 0);
    chk("t5_we", 32'(rf_we), 0);
    tick();
    chk("t5_we2", 32'(rf_we), 0);

    // T6: full queue dropped by reset
    expect_wr(5'd22, 32'h7);
    expect_wr(5'd23, 32'h8);
    pipe_we = 1'b1; pipe_waddr = 5'd22; pipe_wdata = 32'h7;
    lu_valid = 1'b1; lu_waddr = 5'd14; lu_wdata = 32'hE;
    tick();
    pipe_waddr = 5'd23; pipe_wdata = 32'h8;
    lu_waddr = 5'd15; lu_wdata = 32'hF;
    tick();
    idle();
    chk("t6_full", 32'(q_count), 2);
    chk("t6_pend", pend_mask, 32'h0000_C000);
    rst = 1'b1;
    tick();
    chk("t6_cnt", 32'(q_count), 0);
    chk("t6_pend0", pend_mask, 0);
    chk("t6_we", 32'(rf_we), 0);
    chk("t6_rdy", 32'(lu_ready), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_no_drain", 32'(rf_we), 0);
    end
    chk("t6_rf14", rf_m[14], 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
